// File: rtl/bit_serializer_if.sv
// +----------------------------------------------------------------------+
// | Module : bit_serializer_if                                           |
// | Brief  : Word handshake and serial-line bundle for bit_serializer.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface bit_serializer_if #(
    parameter int W = 8
);
    localparam int IW = $clog2(W + 1);

    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic          ser_out;
    logic          bit_valid;
    logic          last_bit;
    logic          busy;
    logic [IW-1:0] bit_idx;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, bit_valid, last_bit, busy, bit_idx
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, bit_valid, last_bit, busy, bit_idx
    );
endinterface

`default_nettype wire

// File: rtl/bit_serializer.sv
// +----------------------------------------------------------------------+
// | Module : bit_serializer                                              |
// | Brief  : Parallel-in/serial-out stage; one bit per clock, framed.    |
// |          Optional even-parity bit: define SERIALIZER_PARITY_EN.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bit_serializer #(
    parameter int W          = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bit_serializer_if.slave bus
);
    localparam int            IW       = $clog2(W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

`ifdef SERIALIZER_PARITY_EN
    localparam logic [IW-1:0] PAR_IDX  = IW'(W);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic          ser_q, ser_d;
    logic          bv_q, bv_d;
    logic          last_q, last_d;
    logic [IW-1:0] idx_q, idx_d;
`ifdef SERIALIZER_PARITY_EN
    logic          par_q, par_d;
`endif

    logic accept;
    logic load;
    logic go_idle;

`ifdef SERIALIZER_PARITY_EN
    assign bus.din_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
    // Ready on the final data bit lets the next word follow with no gap.
    assign bus.din_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && last_q);
`endif

    assign accept        = bus.din_valid && bus.din_ready;
    assign bus.ser_out   = ser_q;
    assign bus.bit_valid = bv_q;
    assign bus.last_bit  = last_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.bit_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        bv_d    = bv_q;
        last_d  = last_q;
        idx_d   = idx_q;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        go_idle = 1'b0;

        case (state_q)
            S_IDLE: begin
                load = accept;
            end
            S_SHIFT: begin
                if (idx_q == LAST_IDX) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = S_PARITY;
                    ser_d   = par_q;
                    bv_d    = 1'b1;
                    last_d  = 1'b1;
                    idx_d   = PAR_IDX;
`else
                    load    = accept;
                    go_idle = !accept;
`endif
                end else begin
                    // Shift register holds the bits not yet driven, next one at the head.
                    ser_d   = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];
                    shreg_d = MSB_FIRST ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};
                    idx_d   = idx_q + IW'(1);
`ifdef SERIALIZER_PARITY_EN
                    last_d  = 1'b0;
`else
                    last_d  = ((idx_q + IW'(1)) == LAST_IDX);
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                load    = accept;
                go_idle = !accept;
            end
`endif
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (load) begin
            state_d = S_SHIFT;
            ser_d   = MSB_FIRST ? bus.din[W-1] : bus.din[0];
            shreg_d = MSB_FIRST ? {bus.din[W-2:0], 1'b0} : {1'b0, bus.din[W-1:1]};
            bv_d    = 1'b1;
            last_d  = 1'b0;
            idx_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            par_d   = ^bus.din;
`endif
        end else if (go_idle) begin
            state_d = S_IDLE;
            ser_d   = IDLE_LEVEL;
            bv_d    = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            ser_q   <= IDLE_LEVEL;
            bv_q    <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            bv_q    <= bv_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// +----------------------------------------------------------------------+
// | Module : tb_bit_serializer                                           |
// | Brief  : Queue-based reference bench for bit_serializer (MSB & LSB). |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bit_serializer;
    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_serializer_if #(.W(W)) mif ();
    bit_serializer_if #(.W(W)) lif ();

    bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (lif.slave)
    );

    typedef struct {
        bit b;
        bit last;
        int idx;
    } ent_t;

    // Front element of each queue is the bit expected on ser_out right now.
    ent_t qm[$];
    ent_t ql[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        mif.din_valid = v;
        lif.din_valid = v;
        mif.din       = d;
        lif.din       = d;
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            qm.push_back('{b: d[W-1-i], last: (i == FL-1), idx: i});
            ql.push_back('{b: d[i],     last: (i == FL-1), idx: i});
        end
`ifdef SERIALIZER_PARITY_EN
        qm.push_back('{b: ^d, last: 1'b1, idx: W});
        ql.push_back('{b: ^d, last: 1'b1, idx: W});
`endif
    endtask

    task automatic compare_all();
        bit   em, el, eb, elst;
        int   ei;
        em   = (qm.size() > 0) ? qm[0].b : 1'b0;
        el   = (ql.size() > 0) ? ql[0].b : 1'b1;
        eb   = (qm.size() > 0);
        elst = (qm.size() > 0) ? qm[0].last : 1'b0;
        ei   = (qm.size() > 0) ? qm[0].idx : 0;
        check_value("m_ser",   32'(mif.ser_out),   32'(em));
        check_value("m_valid", 32'(mif.bit_valid), 32'(eb));
        check_value("m_last",  32'(mif.last_bit),  32'(elst));
        check_value("m_idx",   32'(mif.bit_idx),   32'(ei));
        check_value("m_busy",  32'(mif.busy),      32'(eb));
        check_value("m_ready", 32'(mif.din_ready), 32'(qm.size() <= 1));
        check_value("l_ser",   32'(lif.ser_out),   32'(el));
        check_value("l_valid", 32'(lif.bit_valid), 32'(eb));
        check_value("l_last",  32'(lif.last_bit),  32'(elst));
        check_value("l_idx",   32'(lif.bit_idx),   32'(ei));
        check_value("l_ready", 32'(lif.din_ready), 32'(ql.size() <= 1));
    endtask

    // One clock: decide acceptance from pre-edge inputs, advance model, check at negedge.
    task automatic tick();
        bit           acc;
        logic [W-1:0] d;
        acc = mif.din_valid && (qm.size() <= 1) && !rst;
        d   = mif.din;
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) push_frame(d);
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] cap;
        int         cnt;

        drive(1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_value("rst_ready", 32'(mif.din_ready), 32'd1);
        check_value("rst_ser",   32'(mif.ser_out),   32'd0);

        // Single MSB-first word
        drive(1'b1, 8'hA5);
        tick();
        cap = {7'd0, mif.ser_out};
        drive(1'b0, '0);
        repeat (7) begin
            tick();
            cap = {cap[6:0], mif.ser_out};
        end
        check_value("a5_bits", 32'(cap), 32'h0000_00A5);
        repeat (3) tick();

        // Back-to-back
        cnt = 0;
        drive(1'b1, 8'hA5);
        tick();
        cnt += int'(mif.bit_valid);
        drive(1'b1, 8'h0A);
        repeat (FL) begin
            tick();
            cnt += int'(mif.bit_valid);
        end
        drive(1'b0, '0);
        repeat (FL - 1) begin
            tick();
            cnt += int'(mif.bit_valid);
        end
        check_value("b2b_valid", 32'(cnt), 32'(2 * FL));
        tick();
        check_value("b2b_end", 32'(mif.bit_valid), 32'd0);
        repeat (2) tick();

        // Backpressure
        drive(1'b1, 8'hFF);
        tick();
        drive(1'b0, '0);
        tick();
        tick();
        check_value("bp_idx2", 32'(mif.bit_idx), 32'd2);
        drive(1'b1, 8'h3C);
        repeat (FL - 3) tick();
        check_value("bp_ready_last", 32'(mif.din_ready), 32'd1);
        tick();
        check_value("bp_next_idx", 32'(mif.bit_idx), 32'd0);
        drive(1'b0, '0);
        repeat (FL + 1) tick();

        // Reset mid-frame
        drive(1'b1, 8'hFF);
        tick();
        drive(1'b0, '0);
        repeat (3) tick();
        check_value("mid_idx3", 32'(mif.bit_idx), 32'd3);
        rst = 1'b1;
        tick();
        check_value("mid_busy",  32'(mif.busy),      32'd0);
        check_value("mid_ready", 32'(mif.din_ready), 32'd1);
        check_value("mid_valid", 32'(mif.bit_valid), 32'd0);
        rst = 1'b0;

        // LSB-first 8'h01
        drive(1'b1, 8'h01);
        tick();
        check_value("lsb_idx0", 32'(lif.bit_idx), 32'd0);
        cap = {7'd0, lif.ser_out};
        drive(1'b0, '0);
        repeat (7) begin
            tick();
            cap = {cap[6:0], lif.ser_out};
        end
        check_value("lsb_01", 32'(cap), 32'h0000_0080);
        repeat (3) tick();

        // Randomized traffic with occasional resets
        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) != 0), W'($urandom));
            tick();
        end
        rst = 1'b0;
        drive(1'b0, '0);
        repeat (2 * FL) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
